// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with credit-limited memory requests,
// an in-order instruction queue and redirect flush. Optional feature: FETCH_MISALIGN_FAULT_EN.
package Instr;
    typedef logic [31:0] enc_t;
endpackage

module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output Instr::enc_t out_enc,
    output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_FAULT_EN
    ,
    output logic        out_fault
`endif
);

    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] outstanding_next;
    logic [PW-1:0] q_head;
    logic [PW-1:0] q_tail;
    logic [PW-1:0] tag_head;
    logic [PW-1:0] tag_tail;

    Instr::enc_t   q_enc  [QUEUE_DEPTH];
    logic [31:0]   q_pc   [QUEUE_DEPTH];
    logic [31:0]   tag_pc [QUEUE_DEPTH];

    logic          fetch_en;
    logic          fault_push;
    logic          req_fire;
    logic          rsp_keep;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_sum;
    logic [31:0]   redirect_target;
    Instr::enc_t   push_enc;
    logic [31:0]   push_pc;

`ifdef FETCH_MISALIGN_FAULT_EN
    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_FAULT_PEND,
        MODE_HALT
    } mode_t;

    mode_t mode;
    mode_t mode_next;
    logic  q_fault [QUEUE_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= MODE_RUN;
        end else begin
            mode <= mode_next;
        end
    end

    // The fault entry is queued only once every stale response has been drained.
    always_comb begin
        mode_next  = mode;
        fault_push = 1'b0;
        if (redirect_valid) begin
            mode_next = (redirect_pc[1:0] != 2'b00) ? MODE_FAULT_PEND : MODE_RUN;
        end else if ((mode == MODE_FAULT_PEND) && (drop == '0)) begin
            fault_push = 1'b1;
            mode_next  = MODE_HALT;
        end
    end

    assign fetch_en        = (mode == MODE_RUN);
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk) begin
        if (push) begin
            q_fault[q_tail] <= fault_push;
        end
    end

    assign out_fault = out_valid && q_fault[q_head];
`else
    assign fetch_en        = 1'b1;
    assign fault_push      = 1'b0;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Request valid is held low while in reset so nothing is issued before the first edge.
    always_comb begin
        credit_sum       = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid   = rst_n && !redirect_valid && fetch_en && (credit_sum < {1'b0, DEPTH_C});
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_keep         = imem_rsp_valid && !redirect_valid && (drop == '0);
        pop              = out_valid && out_ready && !redirect_valid;
        push             = rsp_keep || fault_push;
        push_enc         = fault_push ? '0 : imem_rsp_data;
        push_pc          = fault_push ? pc : tag_pc[tag_head];
        outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    end

    assign imem_req_addr = pc;

    // Tag pointers keep advancing across redirects so stale responses still retire their tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (req_fire) begin
                tag_tail <= tag_tail + PW'(1);
            end
            if (imem_rsp_valid) begin
                tag_head <= tag_head + PW'(1);
            end
            if (redirect_valid) begin
                pc     <= redirect_target;
                count  <= '0;
                q_head <= '0;
                q_tail <= '0;
                drop   <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    q_tail <= q_tail + PW'(1);
                end
                if (pop) begin
                    q_head <= q_head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_tail] <= pc;
        end
        if (push) begin
            q_enc[q_tail] <= push_enc;
            q_pc[q_tail]  <= push_pc;
        end
    end

    assign out_valid = (count != '0);
    assign out_enc   = out_valid ? q_enc[q_head] : '0;
    assign out_pc    = out_valid ? q_pc[q_head] : '0;

    a_counter_bounds: assert property (@(posedge clk) disable iff (!rst_n)
        (count <= DEPTH_C) && (outstanding <= DEPTH_C) && (drop <= DEPTH_C) && (drop <= outstanding));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model and a
// queue-level reference model checked every cycle.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int unsigned QD  = 4;
`ifdef FETCH_MISALIGN_FAULT_EN
    localparam logic [31:0] B2B_PC = 32'h0000_4004;
`else
    localparam logic [31:0] B2B_PC = 32'h0000_4006;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    Instr::enc_t out_enc;
    logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_FAULT_EN
    logic        out_fault;
    int          fault_seen;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_enc(out_enc),
        .out_pc(out_pc)
`ifdef FETCH_MISALIGN_FAULT_EN
        ,
        .out_fault(out_fault)
`endif
    );

    typedef struct { logic [31:0] enc; logic [31:0] pc; logic fault; } ent_t;
    typedef struct { logic [31:0] addr; logic stale; } fl_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        mq[$];
    fl_t         fl[$];
    mreq_t       memq[$];
    logic [31:0] acc_log[$];
    logic [31:0] out_log[$];
    logic [31:0] addr_log[$];
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_fpend;

    logic        s_req_ready;
    logic        s_out_ready;
    logic        s_redir;
    logic [31:0] s_redir_pc;
    int          lat;
    int          cyc;
    int          last_due;
    int          first_acc;
    int          first_ov;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        out_log.delete();
        addr_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_enc", out_enc, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        memq.delete();
        mq.delete();
        fl.delete();
        m_pc     = RPC;
        m_halt   = 1'b0;
        m_fpend  = 1'b0;
        last_due = -1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic step();
        logic        exp_rv;
        logic        fire;
        logic        rsp;
        logic        fpush;
        logic [31:0] rdata;
        int          due;
        @(negedge clk);
        imem_req_ready = s_req_ready;
        out_ready      = s_out_ready;
        redirect_valid = s_redir;
        redirect_pc    = s_redir_pc;
        rsp   = 1'b0;
        rdata = '0;
        if ((memq.size() != 0) && (memq[0].due <= cyc)) begin
            rsp   = 1'b1;
            rdata = mdata(memq[0].addr);
            memq.delete(0);
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? rdata : $urandom();
        #1;
        exp_rv = !s_redir && !m_halt && ((mq.size() + fl.size()) < QD);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_enc", out_enc, mq[0].enc);
            chk("out_pc", out_pc, mq[0].pc);
`ifdef FETCH_MISALIGN_FAULT_EN
            chk("out_fault", 32'(out_fault), 32'(mq[0].fault));
            if (out_fault) fault_seen++;
`endif
        end
        addr_log.push_back(imem_req_addr);
        if (imem_req_valid && imem_req_ready) begin
            acc_log.push_back(imem_req_addr);
            if (first_acc < 0) first_acc = cyc;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{imem_req_addr, due});
        end
        if (out_valid && (first_ov < 0)) first_ov = cyc;
        if (out_valid && out_ready && !s_redir) out_log.push_back(out_pc);

        fire  = exp_rv && s_req_ready;
        fpush = m_fpend && !s_redir && (fl.size() == 0);
        if ((mq.size() != 0) && s_out_ready && !s_redir) mq.delete(0);
        if (rsp) begin
            chk("rsp_expected", 32'(fl.size() != 0), 32'd1);
            if (fl.size() != 0) begin
                if (!fl[0].stale && !s_redir) mq.push_back('{rdata, fl[0].addr, 1'b0});
                fl.delete(0);
            end
        end
        if (fpush) begin
            mq.push_back('{32'd0, m_pc, 1'b1});
            m_fpend = 1'b0;
        end
        if (fire) begin
            fl.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (s_redir) begin
            mq.delete();
            foreach (fl[i]) fl[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_FAULT_EN
            if (s_redir_pc[1:0] != 2'b00) begin
                m_pc    = s_redir_pc;
                m_halt  = 1'b1;
                m_fpend = 1'b1;
            end else begin
                m_pc    = s_redir_pc;
                m_halt  = 1'b0;
                m_fpend = 1'b0;
            end
`else
            m_pc = s_redir_pc & 32'hFFFF_FFFC;
`endif
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        logic rdy_pat [10];
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        lat   = 1;
        s_req_ready = 1'b0;
        s_out_ready = 1'b0;
        s_redir     = 1'b0;
        s_redir_pc  = '0;
`ifdef FETCH_MISALIGN_FAULT_EN
        fault_seen = 0;
`endif

        // Streaming fetch, single-cycle memory.
        do_reset();
        clear_logs();
        first_acc = -1;
        first_ov  = -1;
        lat = 1;
        s_req_ready = 1'b1;
        s_out_ready = 1'b1;
        repeat (12) step();
        chk("p1_acc0", acc_log[0], 32'h100);
        chk("p1_acc1", acc_log[1], 32'h104);
        chk("p1_acc2", acc_log[2], 32'h108);
        chk("p1_out0", out_log[0], 32'h100);
        chk("p1_out1", out_log[1], 32'h104);
        chk("p1_out2", out_log[2], 32'h108);
        chk("p1_latency", 32'(first_ov - first_acc), 32'd2);

        // Decoder stalled: credit caps requests at the queue depth.
        do_reset();
        clear_logs();
        s_out_ready = 1'b0;
        repeat (10) step();
        chk("p2_acc_cnt", 32'(acc_log.size()), 32'd4);
        chk("p2_no_pop", 32'(out_log.size()), 32'd0);
        s_out_ready = 1'b1;
        repeat (12) step();
        chk("p2_out0", out_log[0], 32'h100);
        chk("p2_out3", out_log[3], 32'h10C);
        chk("p2_out4", out_log[4], 32'h110);
        chk("p2_resumed", 32'(acc_log.size() > 4), 32'd1);

        // Memory stall in the middle of a request.
        do_reset();
        clear_logs();
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            s_req_ready = rdy_pat[i];
            step();
        end
        chk("p3_stall_addr_a", addr_log[2], 32'h108);
        chk("p3_stall_addr_b", addr_log[3], 32'h108);
        chk("p3_acc2", acc_log[2], 32'h108);
        chk("p3_acc3", acc_log[3], 32'h10C);

        // Redirect with three requests in flight.
        do_reset();
        clear_logs();
        lat = 3;
        s_req_ready = 1'b1;
        s_out_ready = 1'b1;
        repeat (3) step();
        s_redir    = 1'b1;
        s_redir_pc = 32'h2000;
        step();
        s_redir = 1'b0;
        repeat (14) step();
        chk("p4_acc_after", acc_log[3], 32'h2000);
        chk("p4_out0", out_log[0], 32'h2000);
        chk("p4_out1", out_log[1], 32'h2004);

        // PC wrap at the top of the address space.
        lat = 1;
        clear_logs();
        s_redir    = 1'b1;
        s_redir_pc = 32'hFFFF_FFF8;
        step();
        s_redir = 1'b0;
        repeat (14) step();
        chk("p5_acc_wrap", acc_log[2], 32'h0000_0000);
        chk("p5_out1", out_log[1], 32'hFFFF_FFFC);
        chk("p5_out2", out_log[2], 32'h0000_0000);
        chk("p5_out3", out_log[3], 32'h0000_0004);

        // Back-to-back redirects: the second one wins.
        clear_logs();
        s_redir    = 1'b1;
        s_redir_pc = 32'h3000;
        step();
        s_redir_pc = B2B_PC;
        step();
        s_redir = 1'b0;
        repeat (10) step();
        chk("p6_out0", out_log[0], 32'h4004);

`ifdef FETCH_MISALIGN_FAULT_EN
        do_reset();
        clear_logs();
        lat = 2;
        repeat (2) step();
        clear_logs();
        fault_seen = 0;
        s_redir    = 1'b1;
        s_redir_pc = 32'h2002;
        step();
        s_redir = 1'b0;
        repeat (8) step();
        chk("pf_no_fetch", 32'(acc_log.size()), 32'd0);
        chk("pf_out0", out_log[0], 32'h2002);
        chk("pf_fault_cnt", 32'(fault_seen), 32'd1);
        s_redir    = 1'b1;
        s_redir_pc = 32'h3000;
        step();
        s_redir = 1'b0;
        repeat (6) step();
        chk("pf_resume", acc_log[0], 32'h3000);
`endif

        // Mixed backpressure and occasional redirects.
        lat = 2;
        for (int i = 0; i < 80; i++) begin
            s_req_ready = ($urandom_range(0, 3) != 0);
            s_out_ready = ($urandom_range(0, 2) != 0);
            s_redir     = ($urandom_range(0, 15) == 0);
            s_redir_pc  = $urandom() & 32'hFFFF_FFFC;
            step();
        end
        s_redir = 1'b0;
        s_out_ready = 1'b1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Generates sequential PCs and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned instruction words in a small in-order queue and presents one Instr::enc_t plus its PC per cycle to the decoder.
- Handles redirects (branch/exception) by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, >= 2; also the maximum number of outstanding requests.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in order, >= 1 cycle after acceptance, never backpressured.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  redirect request, single-cycle pulse.
- redirect_pc  in  32  new fetch PC.
- out_valid  out  1  queue head valid to decoder.
- out_ready  in  1  decoder consumes head.
- out_enc  out  Instr::enc_t  instruction at queue head.
- out_pc  out  32  PC of out_enc.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; queue empty.
  - outstanding=0, drop=0.
  - imem_req_valid=0, out_valid=0, out_enc=0, out_pc=0.
- Credit rule: imem_req_valid = !redirect_valid && (count + outstanding < QUEUE_DEPTH). A full queue plus in-flight requests never overflows.
- imem_req_addr = pc.
- Request handshake:
  - On req_valid && req_ready: pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); outstanding += 1.
  - A separate pc tag FIFO records the address of each accepted request.
  - Valid/addr stay stable while ready=0 unless a redirect occurs.
- Response:
  - outstanding -= 1 on each response.
  - If drop > 0 (or redirect_valid this cycle): discard the word, drop -= 1.
  - Otherwise push {data, tag pc} into the queue.
- Output:
  - out_valid = count != 0; out_enc/out_pc come from the queue head (registered storage, no comb path from imem_rsp).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle with count=QUEUE_DEPTH cannot occur (credit); push and pop when empty is not bypassed (1-cycle min latency response -> out_valid).
- Redirect (redirect_valid=1):
  - Next cycle: queue count=0, out_valid=0, pc=redirect_pc & ~3.
  - drop = outstanding after that cycle's response accounting.
  - No request is issued in the redirect cycle; a response arriving in the redirect cycle is discarded.
  - A pop requested in the redirect cycle is ignored (the queue is flushed anyway).
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Counters: count, outstanding, and drop are each clog2(QUEUE_DEPTH)+1 bits wide; none may exceed QUEUE_DEPTH (assertion).
- Reset mid-operation: all state is cleared immediately. Memory-side responses after reset are the integration's responsibility (memory is reset on the same rst_n).

Optional Feature:
- Macro FETCH_MISALIGN_FAULT_EN.
- Defined:
  - Adds output out_fault (1 bit).
  - A redirect with redirect_pc[1:0]!=0 does not mask the PC. Instead, after flushing and draining stale responses (drop=0), exactly one entry is presented: out_pc=redirect_pc, out_enc=0, out_fault=1. Fetching then halts (imem_req_valid=0) until the next redirect.
  - out_fault=0 for all normal entries; reset value 0.
- Undefined:
  - No out_fault port; misaligned redirect_pc is silently aligned (& ~3).

Test Plan:
- Reset with RESET_PC=32'h100, mem always ready, 1-cycle latency, out_ready=1 -> requests 0x100, 0x104, 0x108…; out_pc sequence identical; first out_valid 2 cycles after the first request.
- out_ready=0 held, QUEUE_DEPTH=4 -> exactly 4 requests accepted, imem_req_valid drops to 0, queue holds 4 entries; releasing out_ready drains in order and fetch resumes.
- imem_req_ready toggling 1,0,0,1 -> imem_req_addr stays at 0x108 through stall; no duplicate or skipped PC.
- 3 requests in flight (latency 3), redirect_pc=32'h2000 -> the 3 old responses are dropped, next out_pc=0x2000, no stale instruction reaches the decoder.
- pc=32'hFFFF_FFFC -> next request 32'h0000_0000; out_pc wraps identically.
- (FETCH_MISALIGN_FAULT_EN) redirect_pc=32'h2002 with 2 in flight -> both dropped, one entry out_fault=1, out_pc=0x2002, no further requests until redirect_pc=0x3000.
